// File: rtl/key_pkg.sv
// -----------------------------------------------------------------------------
// key_pkg
// Shared definitions for the key event decoder: number of buttons, the
// per-button FSM state encoding and the lowest-index priority helper used to
// build key_code.
// -----------------------------------------------------------------------------
package key_pkg;

    localparam int NUM_KEYS = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } key_state_t;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [2:0] lowest_index(input logic [NUM_KEYS-1:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_event_fsm.sv
// -----------------------------------------------------------------------------
// key_event_fsm
// Per-button state machine (IDLE / PRESSED / HELD) with its tick hold counter.
// Edge inputs are acted on at the first clock edge; the resulting event is
// captured in an internal event register and re-registered onto the pulse
// outputs one edge later, giving every pulse a fixed two-cycle latency from
// the button transition.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   rise / fall  button edge flags (one cycle each)
//   tick         prescaler tick, one cycle wide
//   press_pulse  one cycle on press
//   long_pulse   one cycle when the hold reaches LONG_TICKS
//   rpt_pulse    one cycle per REPEAT_TICKS while held after a long press
//   rel_pulse    one cycle on release
// -----------------------------------------------------------------------------
module key_event_fsm
    import key_pkg::*;
#(
    parameter int LONG_TICKS   = 1000,
    parameter int REPEAT_TICKS = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic rise,
    input  logic fall,
    input  logic tick,
    output logic press_pulse,
    output logic long_pulse,
    output logic rpt_pulse,
    output logic rel_pulse
);

    localparam int MAX_TICKS = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS + 1);

    key_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             press_ev;
    logic             long_ev;
    logic             rpt_ev;
    logic             rel_ev;

    // The counter is cleared whenever it reaches a threshold, so cnt_inc never
    // exceeds MAX_TICKS and fits in CNT_W bits.
    assign cnt_inc = cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            press_ev    <= 1'b0;
            long_ev     <= 1'b0;
            rpt_ev      <= 1'b0;
            rel_ev      <= 1'b0;
            press_pulse <= 1'b0;
            long_pulse  <= 1'b0;
            rpt_pulse   <= 1'b0;
            rel_pulse   <= 1'b0;
        end else begin
            // Second stage: events from the previous edge become the outputs.
            press_pulse <= press_ev;
            long_pulse  <= long_ev;
            rpt_pulse   <= rpt_ev;
            rel_pulse   <= rel_ev;

            press_ev <= 1'b0;
            long_ev  <= 1'b0;
            rpt_ev   <= 1'b0;
            rel_ev   <= 1'b0;

            case (state)
                IDLE: begin
                    if (rise) begin
                        state    <= PRESSED;
                        cnt      <= '0;
                        press_ev <= 1'b1;
                    end
                end
                PRESSED: begin
                    // Release is checked first so a coincident threshold tick
                    // never produces a long pulse.
                    if (fall) begin
                        state  <= IDLE;
                        cnt    <= '0;
                        rel_ev <= 1'b1;
                    end else if (tick) begin
                        if (cnt_inc == CNT_W'(LONG_TICKS)) begin
                            state   <= HELD;
                            cnt     <= '0;
                            long_ev <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end
                HELD: begin
                    if (fall) begin
                        state  <= IDLE;
                        cnt    <= '0;
                        rel_ev <= 1'b1;
                    end else if (tick) begin
                        if (cnt_inc == CNT_W'(REPEAT_TICKS)) begin
                            cnt    <= '0;
                            rpt_ev <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_event_decoder.sv
// -----------------------------------------------------------------------------
// key_event_decoder
// Turns NUM_KEYS debounced button levels into press / long-press / auto-repeat
// / release pulses. Holds the shared tick prescaler and the button edge
// detector, runs one key_event_fsm per button and derives a single key code
// from the press and repeat pulses (lowest index wins).
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   button       debounced button levels, 1 = pressed
//   press_pulse  per-button press pulses
//   long_pulse   per-button long-press pulses
//   rpt_pulse    per-button auto-repeat pulses
//   rel_pulse    per-button release pulses
//   key_valid    any press or repeat pulse is high
//   key_code     lowest button index with press or repeat pulse, 0 when idle
// -----------------------------------------------------------------------------
module key_event_decoder
    import key_pkg::*;
#(
    parameter int TICK_DIV     = 100000,
    parameter int LONG_TICKS   = 1000,
    parameter int REPEAT_TICKS = 200
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] button,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] long_pulse,
    output logic [NUM_KEYS-1:0] rpt_pulse,
    output logic [NUM_KEYS-1:0] rel_pulse,
    output logic                key_valid,
    output logic [2:0]          key_code
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PRE_W-1:0]    pre_cnt;
    logic                tick;
    logic [NUM_KEYS-1:0] btn_q;
    logic [NUM_KEYS-1:0] rise;
    logic [NUM_KEYS-1:0] fall;
    logic [NUM_KEYS-1:0] code_src;

    // btn_q is cleared by reset, so a button already held at reset release is
    // seen as a rising edge on the first cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_cnt <= '0;
            tick    <= 1'b0;
            btn_q   <= '0;
        end else begin
            btn_q <= button;
            if (pre_cnt == PRE_W'(TICK_DIV - 1)) begin
                pre_cnt <= '0;
                tick    <= 1'b1;
            end else begin
                pre_cnt <= pre_cnt + PRE_W'(1);
                tick    <= 1'b0;
            end
        end
    end

    assign rise = button & ~btn_q;
    assign fall = ~button & btn_q;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_event_fsm #(
            .LONG_TICKS   (LONG_TICKS),
            .REPEAT_TICKS (REPEAT_TICKS)
        ) u_fsm (
            .clk         (clk),
            .rst         (rst),
            .rise        (rise[g]),
            .fall        (fall[g]),
            .tick        (tick),
            .press_pulse (press_pulse[g]),
            .long_pulse  (long_pulse[g]),
            .rpt_pulse   (rpt_pulse[g]),
            .rel_pulse   (rel_pulse[g])
        );
    end

    // Long and release pulses do not produce a key code.
    assign code_src  = press_pulse | rpt_pulse;
    assign key_valid = |code_src;
    assign key_code  = lowest_index(code_src);

endmodule

// File: tb/tb_key_event_decoder.sv
// -----------------------------------------------------------------------------
// tb_key_event_decoder
// Directed and randomised button holds against key_event_decoder with a small
// tick schedule (TICK_DIV=4, LONG_TICKS=5, REPEAT_TICKS=3). Each hold plans its
// expected pulse cycles up front from the known tick schedule; the step task
// compares the DUT output word against the queue every cycle.
// -----------------------------------------------------------------------------
module tb_key_event_decoder;

    localparam int TD = 4;
    localparam int LT = 5;
    localparam int RT = 3;
    localparam int NK = 5;
    localparam int W  = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NK-1:0] button = '0;
    logic [NK-1:0] press_pulse;
    logic [NK-1:0] long_pulse;
    logic [NK-1:0] rpt_pulse;
    logic [NK-1:0] rel_pulse;
    logic          key_valid;
    logic [2:0]    key_code;
    logic [W-1:0]  obs;

    key_event_decoder #(
        .TICK_DIV     (TD),
        .LONG_TICKS   (LT),
        .REPEAT_TICKS (RT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .button      (button),
        .press_pulse (press_pulse),
        .long_pulse  (long_pulse),
        .rpt_pulse   (rpt_pulse),
        .rel_pulse   (rel_pulse),
        .key_valid   (key_valid),
        .key_code    (key_code)
    );

    // Clock / reset-relative cycle count: cyc = number of rising edges since
    // reset release.
    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    assign obs = {press_pulse, long_pulse, rpt_pulse, rel_pulse, key_valid, key_code};

    // Scoreboard
    logic [W-1:0]  exp_q[$];
    int            exp_cyc_q[$];
    logic [19:0]   pend[int];
    int            n_pass  = 0;
    int            n_total = 0;

    // Expected output word from {press, long, rpt, rel} bits.
    function automatic logic [W-1:0] make_vec(input logic [19:0] ev);
        logic [NK-1:0] src;
        logic [2:0]    code;
        logic          found;
        src   = ev[19:15] | ev[9:5];
        code  = 3'd0;
        found = 1'b0;
        for (int i = 0; i < NK; i++) begin
            if (!found && src[i]) begin
                code  = 3'(i);
                found = 1'b1;
            end
        end
        return {ev, found, code};
    endfunction

    // kind: 0 press, 1 long, 2 repeat, 3 release
    task automatic add_ev(input int cy, input int kind, input int key);
        if (!pend.exists(cy)) pend[cy] = '0;
        pend[cy][(3 - kind) * NK + key] = 1'b1;
    endtask

    task automatic commit();
        foreach (pend[cy]) begin
            exp_cyc_q.push_back(cy);
            exp_q.push_back(make_vec(pend[cy]));
        end
        pend.delete();
    endtask

    // Button(s) in mask go high after edge c and low after edge d. Ticks are
    // sampled on edges TD*m+1 (m >= 1); only ticks after the press edge c+1
    // and strictly before the release edge d+1 count. Each event shows up on
    // the outputs one edge after the FSM acts on it.
    task automatic plan(input logic [NK-1:0] mask, input int c, input int d, input bit with_rel);
        int m0;
        int e;
        m0 = (c + TD) / TD;
        for (int key = 0; key < NK; key++) begin
            if (mask[key]) begin
                add_ev(c + 2, 0, key);
                e = TD * (m0 + LT - 1) + 1;
                if (e < d + 1) add_ev(e + 1, 1, key);
                for (int k = LT - 1 + RT; TD * (m0 + k) + 1 < d + 1; k += RT)
                    add_ev(TD * (m0 + k) + 2, 2, key);
                if (with_rel) add_ev(d + 2, 3, key);
            end
        end
        commit();
    endtask

    // Advance one cycle and check the outputs away from the active edge.
    task automatic step();
        logic [W-1:0] exp_v;
        @(negedge clk);
        if (!rst) begin
            n_total++;
            assert (obs === '0) n_pass++;
            else $error("FAIL reset_zero cyc=%0d observed=%h expected=%h", cyc, obs, {W{1'b0}});
        end else begin
            exp_v = '0;
            if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
                exp_v = exp_q.pop_front();
                void'(exp_cyc_q.pop_front());
            end
            if (obs !== '0 || exp_v !== '0) begin
                n_total++;
                assert (obs === exp_v) n_pass++;
                else $error("FAIL pulse_word cyc=%0d observed=%h expected=%h", cyc, obs, exp_v);
            end
        end
    endtask

    task automatic hold(input logic [NK-1:0] mask, input int n);
        plan(mask, cyc, cyc + n, 1'b1);
        button = button | mask;
        repeat (n) step();
        button = button & ~mask;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) step();
        n_total++;
        assert (exp_q.size() == 0) n_pass++;
        else $error("FAIL drain observed=%0d expected=0 pending events", exp_q.size());
        exp_q.delete();
        exp_cyc_q.delete();
        repeat (3) step();
    endtask

    initial begin
        int c;
        int m0;
        int lcyc;
        int n;
        int key;

        // Button 4 held through reset: outputs stay 0, press two cycles after release.
        button = 5'b10000;
        repeat (3) step();
        rst = 1'b1;
        hold(5'b10000, 8);
        drain();

        // Short press of button 2: press then release, no long.
        hold(5'b00100, 10);
        drain();

        // Button 0 held 60 cycles: long after 5 ticks, repeats every 3 ticks.
        hold(5'b00001, 60);
        drain();

        // Buttons 1 and 3 together: both press bits, key_code 1.
        hold(5'b01010, 8);
        drain();

        // Release exactly on the fifth tick: release only.
        c  = cyc;
        m0 = (c + TD) / TD;
        n  = TD * (m0 + LT - 1) + 1 - 1 - c;
        hold(5'b00010, n);
        drain();

        // Reset while HELD, released with the button low: no pulses, then a
        // fresh hold behaves like a first press.
        c    = cyc;
        m0   = (c + TD) / TD;
        lcyc = TD * (m0 + LT - 1) + 2;
        plan(5'b00001, c, lcyc + 2, 1'b0);
        button = 5'b00001;
        while (cyc < lcyc + 2) step();
        rst    = 1'b0;
        button = '0;
        repeat (3) step();
        rst = 1'b1;
        repeat (30) step();
        drain();
        hold(5'b00001, 30);
        drain();

        // Random single-button holds.
        for (int i = 0; i < 4; i++) begin
            key = $urandom_range(0, NK - 1);
            n   = $urandom_range(3, 45);
            hold(5'(1 << key), n);
            drain();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
